iter_alu_mdu: RTL and testbench

- Parametrised execute-stage unit: the single-cycle integer ALU plus an iterative RV32M multiply/divide engine behind a valid/ready handshake.
- Sits in the EX stage of the pipelined core.
- While an iterative op is in flight, `busy` stalls the earlier pipeline stages.
- A destination tag travels with each op so writeback can match results to their destination registers.

---
 rtl/iter_alu_mdu.sv | 219 +++++++++++++++++++++
 tb/tb_iter_alu_mdu.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_alu_mdu.sv
// iter_alu_mdu: execute-stage integer unit. Simple ALU ops complete one cycle
// after acceptance. RV32M multiply/divide ops run an XLEN-step iterative
// engine (shift-add multiply, restoring divide on magnitudes) and then apply
// the sign in one final cycle.
//
// Ports:
//   clk, reset (sync, active-high), flush (sync abort of the in-flight op)
//   in_valid/in_ready   : op handshake; in_ready is combinational
//   in_op, in_btype     : operation code and branch compare type
//   in_a, in_b, in_tag  : operands and destination tag, captured on accept
//   out_valid           : one-cycle result strobe
//   out_res, out_bcond, out_tag : registered result, held between strobes
//   busy                : iterative op in progress; upstream must stall
module iter_alu_mdu #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [2:0]       in_btype,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [XLEN-1:0]  out_res,
    output logic             out_bcond,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int SH_W  = $clog2(XLEN);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_AND = 5'd2,  OP_OR = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4,  OP_SLL = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
    localparam logic [4:0] OP_SLT = 5'd8,  OP_SLTU = 5'd9, OP_MUL = 5'd10, OP_MULH = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14;
    localparam logic [4:0] OP_DIVU = 5'd15, OP_REM = 5'd16, OP_REMU = 5'd17;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESULT} state_t;

    state_t             r_state, w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [XLEN-1:0]    r_hi, r_lo, r_opb, r_res;
    logic [4:0]         r_op;
    logic               r_neg, r_neg_rem, r_bcond;
    logic [TAG_W-1:0]   r_tag, r_out_tag;

    logic               w_accept, w_is_iter, w_is_div, w_div_zero, w_div_ovf, w_special, w_start_iter;
    logic [SH_W-1:0]    w_shamt;
    logic [XLEN-1:0]    w_simple_res, w_spec_res, w_imm_res, w_mag_a, w_mag_b;
    logic               w_bcond, w_a_neg, w_b_neg;
    logic [XLEN:0]      w_mul_sum, w_div_trial, w_div_diff;
    logic               w_div_ge;
    logic [2*XLEN-1:0]  w_prod_mag, w_prod;
    logic [XLEN-1:0]    w_quo, w_rem, w_final;

    assign w_accept     = in_valid & in_ready & ~flush;
    assign w_is_iter    = (in_op >= OP_MUL) && (in_op <= OP_REMU);
    assign w_is_div     = (in_op >= OP_DIV) && (in_op <= OP_REMU);
    assign w_div_zero   = w_is_div && (in_b == '0);
    assign w_div_ovf    = ((in_op == OP_DIV) || (in_op == OP_REM)) && (in_a == MIN_NEG) && (in_b == '1);
    // Divide-by-zero and signed overflow have fixed answers, so they bypass the engine.
    assign w_special    = w_div_zero | w_div_ovf;
    assign w_start_iter = w_is_iter & ~w_special;
    assign w_shamt      = in_b[SH_W-1:0];

    always_comb begin
        w_simple_res = '0;
        w_bcond      = 1'b0;
        case (in_op)
            OP_ADD:  w_simple_res = in_a + in_b;
            OP_SUB: begin
                w_simple_res = in_a - in_b;
                case (in_btype)
                    3'd0:    w_bcond = (in_a == in_b);
                    3'd1:    w_bcond = (in_a != in_b);
                    3'd4:    w_bcond = ($signed(in_a) < $signed(in_b));
                    3'd5:    w_bcond = ($signed(in_a) >= $signed(in_b));
                    3'd6:    w_bcond = (in_a < in_b);
                    3'd7:    w_bcond = (in_a >= in_b);
                    default: w_bcond = 1'b0;
                endcase
            end
            OP_AND:  w_simple_res = in_a & in_b;
            OP_OR:   w_simple_res = in_a | in_b;
            OP_XOR:  w_simple_res = in_a ^ in_b;
            OP_SLL:  w_simple_res = in_a << w_shamt;
            OP_SRL:  w_simple_res = in_a >> w_shamt;
            OP_SRA:  w_simple_res = $unsigned($signed(in_a) >>> w_shamt);
            OP_SLT:  w_simple_res = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OP_SLTU: w_simple_res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
            default: w_simple_res = '0;
        endcase
    end

    always_comb begin
        w_spec_res = '0;
        if (w_div_zero)
            w_spec_res = ((in_op == OP_DIV) || (in_op == OP_DIVU)) ? '1 : in_a;
        else if (w_div_ovf)
            w_spec_res = (in_op == OP_DIV) ? in_a : '0;
    end

    assign w_imm_res = w_special ? w_spec_res : w_simple_res;

    // The engine works on magnitudes; signs are recorded and applied at the end.
    assign w_a_neg = in_a[XLEN-1] & ((in_op == OP_MULH) || (in_op == OP_MULHSU) ||
                                     (in_op == OP_DIV) || (in_op == OP_REM));
    assign w_b_neg = in_b[XLEN-1] & ((in_op == OP_MULH) || (in_op == OP_DIV) || (in_op == OP_REM));
    assign w_mag_a = w_a_neg ? -in_a : in_a;
    assign w_mag_b = w_b_neg ? -in_b : in_b;

    // One shift-add step: {r_hi, r_lo} is the partial product, r_lo[0] the next multiplier bit.
    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
    // One restoring-divide step: r_hi is the partial remainder, r_lo shifts dividend out / quotient in.
    assign w_div_trial = {r_hi, r_lo[XLEN-1]};
    assign w_div_ge    = (w_div_trial >= {1'b0, r_opb});
    assign w_div_diff  = w_div_trial - {1'b0, r_opb};

    assign w_prod_mag = {r_hi, r_lo};
    assign w_prod     = r_neg ? -w_prod_mag : w_prod_mag;
    assign w_quo      = r_neg ? -r_lo : r_lo;
    assign w_rem      = r_neg_rem ? -r_hi : r_hi;

    always_comb begin
        case (r_op)
            OP_MUL:                         w_final = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   w_final = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:                w_final = w_quo;
            default:                        w_final = w_rem;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_BUSY:  w_state_next = (r_cnt == '0) ? S_RESULT : S_BUSY;
                default: begin
                    if (w_accept) w_state_next = w_start_iter ? S_BUSY : S_RESULT;
                    else          w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (r_state != S_BUSY) & ~reset;
        busy      = (r_state == S_BUSY);
        out_valid = (r_state == S_RESULT);
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_opb     <= '0;
            r_op      <= '0;
            r_neg     <= 1'b0;
            r_neg_rem <= 1'b0;
            r_tag     <= '0;
            r_res     <= '0;
            r_bcond   <= 1'b0;
            r_out_tag <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            if (w_start_iter) begin
                r_cnt     <= CNT_W'(XLEN);
                r_hi      <= '0;
                r_lo      <= w_mag_a;
                r_opb     <= w_mag_b;
                r_op      <= in_op;
                r_neg     <= w_a_neg ^ w_b_neg;
                r_neg_rem <= w_a_neg;
                r_tag     <= in_tag;
            end else begin
                r_res     <= w_imm_res;
                r_bcond   <= w_special ? 1'b0 : w_bcond;
                r_out_tag <= in_tag;
            end
        end else if (r_state == S_BUSY) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
                if (r_op <= OP_MULHU) begin
                    {r_hi, r_lo} <= {w_mul_sum, r_lo[XLEN-1:1]};
                end else begin
                    r_hi <= w_div_ge ? w_div_diff[XLEN-1:0] : w_div_trial[XLEN-1:0];
                    r_lo <= {r_lo[XLEN-2:0], w_div_ge};
                end
            end else begin
                r_res     <= w_final;
                r_bcond   <= 1'b0;
                r_out_tag <= r_tag;
            end
        end
    end

    assign out_res   = r_res;
    assign out_bcond = r_bcond;
    assign out_tag   = r_out_tag;
endmodule

// File: tb/tb_iter_alu_mdu.sv
module tb_iter_alu_mdu;
    localparam int XLEN = 32;
    localparam int IL   = XLEN + 1;   // accept edge to result edge for iterative ops

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    logic [4:0]  in_op;
    logic [2:0]  in_btype;
    logic [31:0] in_a, in_b;
    logic [4:0]  in_tag;
    logic        out_valid, out_bcond, busy;
    logic [31:0] out_res;
    logic [4:0]  out_tag;

    int tests = 0;
    int fails = 0;
    logic [31:0] last_res;
    logic [4:0]  last_tag;

    iter_alu_mdu #(.XLEN(XLEN), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_btype(in_btype), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_res(out_res), .out_bcond(out_bcond), .out_tag(out_tag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [4:0]  op;
        logic [2:0]  bt;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] res;
        logic        bc;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [2:0] bt, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tg);
        in_valid = 1'b1; in_op = op; in_btype = bt; in_a = a; in_b = b; in_tag = tg;
    endtask

    // Garbage on the inputs after acceptance must not disturb the op in flight.
    task automatic scramble();
        in_valid = 1'b0;
        in_op    = 5'($urandom);
        in_btype = 3'($urandom);
        in_a     = $urandom;
        in_b     = $urandom;
        in_tag   = 5'($urandom);
    endtask

    // Called just after the accept edge; returns in the out_valid cycle.
    task automatic wait_check(input string nm, input int exp_e, input logic [31:0] er,
                              input logic eb, input logic [4:0] et, input logic iter);
        int   e = 0;
        logic stall_ok = 1'b1;
        while (!out_valid && e < 100) begin
            if (!(busy === 1'b1 && in_ready === 1'b0)) stall_ok = 1'b0;
            tick();
            e++;
        end
        chk({nm, " latency"}, 64'(e), 64'(exp_e));
        chk({nm, " res"}, 64'(out_res), 64'(er));
        chk({nm, " bcond"}, 64'(out_bcond), 64'(eb));
        chk({nm, " tag"}, 64'(out_tag), 64'(et));
        chk({nm, " busy at result"}, 64'(busy), 64'd0);
        if (iter) chk({nm, " stall while busy"}, 64'(stall_ok), 64'd1);
        $display("[TB] %s: res=%h bcond=%0d tag=%0d cycles=%0d", nm, out_res, out_bcond, out_tag, e + 1);
        last_res = er;
        last_tag = et;
    endtask

    task automatic run_op(input string nm, input logic [4:0] op, input logic [2:0] bt,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] tg,
                          input logic [31:0] er, input logic eb, input int exp_e);
        chk({nm, " ready"}, 64'(in_ready), 64'd1);
        drive(op, bt, a, b, tg);
        tick();
        scramble();
        wait_check(nm, exp_e, er, eb, tg, exp_e != 0);
        tick();
        chk({nm, " strobe one cycle"}, 64'(out_valid), 64'd0);
        chk({nm, " res held"}, 64'(out_res), 64'(er));
    endtask

    // Reference model: RV32I/M semantics from plain arithmetic on wide integers.
    function automatic logic [32:0] ref_model(input logic [4:0] op, input logic [2:0] bt,
                                              input logic [31:0] a, input logic [31:0] b);
        int          sa = a;
        int          sb = b;
        longint      la = longint'(sa);
        longint      lb = longint'(sb);
        longint      ub = {32'b0, b};
        logic [63:0] p;
        logic [31:0] r = '0;
        logic        c = 1'b0;
        case (op)
            5'd0:  r = a + b;
            5'd1: begin
                r = a - b;
                case (bt)
                    3'd0: c = (a == b);
                    3'd1: c = (a != b);
                    3'd4: c = (sa < sb);
                    3'd5: c = (sa >= sb);
                    3'd6: c = (a < b);
                    3'd7: c = (a >= b);
                    default: c = 1'b0;
                endcase
            end
            5'd2:  r = a & b;
            5'd3:  r = a | b;
            5'd4:  r = a ^ b;
            5'd5:  r = a << b[4:0];
            5'd6:  r = a >> b[4:0];
            5'd7:  r = 32'(sa >>> b[4:0]);
            5'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
            5'd9:  r = (a < b) ? 32'd1 : 32'd0;
            5'd10: begin p = 64'(la * lb); r = p[31:0]; end
            5'd11: begin p = 64'(la * lb); r = p[63:32]; end
            5'd12: begin p = 64'(la * ub); r = p[63:32]; end
            5'd13: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            5'd14: r = (b == 0) ? 32'hFFFFFFFF : (a == 32'h80000000 && sb == -1) ? a : 32'(sa / sb);
            5'd15: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            5'd16: r = (b == 0) ? a : (a == 32'h80000000 && sb == -1) ? 32'd0 : 32'(sa % sb);
            5'd17: r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
        return {c, r};
    endfunction

    function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < 5'd10 || op > 5'd17) return 0;
        if (op >= 5'd14 && b == 0) return 0;
        if ((op == 5'd14 || op == 5'd16) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 0;
        return IL;
    endfunction

    initial begin
        logic [32:0] m;
        logic [4:0]  rop;
        logic [2:0]  rbt;
        logic [31:0] ra, rb;
        int          nv;

        vecs.push_back('{"add 7+-3", 5'd0, 3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 32'd4, 1'b0, 0});
        vecs.push_back('{"sub eq", 5'd1, 3'd0, 32'd9, 32'd9, 5'd1, 32'd0, 1'b1, 0});
        vecs.push_back('{"sub ltu eq-ops", 5'd1, 3'd6, 32'd9, 32'd9, 5'd2, 32'd0, 1'b0, 0});
        vecs.push_back('{"sub lt", 5'd1, 3'd4, 32'hFFFFFFFF, 32'd1, 5'd3, 32'hFFFFFFFE, 1'b1, 0});
        vecs.push_back('{"sub ltu", 5'd1, 3'd6, 32'hFFFFFFFF, 32'd1, 5'd4, 32'hFFFFFFFE, 1'b0, 0});
        vecs.push_back('{"sub ne", 5'd1, 3'd1, 32'd3, 32'd4, 5'd6, 32'hFFFFFFFF, 1'b1, 0});
        vecs.push_back('{"sub ge", 5'd1, 3'd5, 32'd3, 32'd4, 5'd7, 32'hFFFFFFFF, 1'b0, 0});
        vecs.push_back('{"sub geu", 5'd1, 3'd7, 32'hFFFFFFFF, 32'd4, 5'd8, 32'hFFFFFFFB, 1'b1, 0});
        vecs.push_back('{"sub btype2", 5'd1, 3'd2, 32'd5, 32'd5, 5'd9, 32'd0, 1'b0, 0});
        vecs.push_back('{"add no bcond", 5'd0, 3'd0, 32'd1, 32'd1, 5'd10, 32'd2, 1'b0, 0});
        vecs.push_back('{"sra by 35", 5'd7, 3'd0, 32'h80000000, 32'd35, 5'd11, 32'hF0000000, 1'b0, 0});
        vecs.push_back('{"srl by 35", 5'd6, 3'd0, 32'h80000000, 32'd35, 5'd12, 32'h10000000, 1'b0, 0});
        vecs.push_back('{"sll by 4", 5'd5, 3'd0, 32'h0000000F, 32'd4, 5'd13, 32'h000000F0, 1'b0, 0});
        vecs.push_back('{"and", 5'd2, 3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd14, 32'hF000F000, 1'b0, 0});
        vecs.push_back('{"or", 5'd3, 3'd0, 32'hF0F0F0F0, 32'h0F000000, 5'd15, 32'hFFF0F0F0, 1'b0, 0});
        vecs.push_back('{"xor", 5'd4, 3'd0, 32'hFFFF0000, 32'hFF00FF00, 5'd16, 32'h00FFFF00, 1'b0, 0});
        vecs.push_back('{"slt", 5'd8, 3'd0, 32'd1, 32'hFFFFFFFF, 5'd17, 32'd0, 1'b0, 0});
        vecs.push_back('{"sltu", 5'd9, 3'd0, 32'd1, 32'hFFFFFFFF, 5'd18, 32'd1, 1'b0, 0});
        vecs.push_back('{"reserved 20", 5'd20, 3'd0, 32'd5, 32'd5, 5'd19, 32'd0, 1'b0, 0});
        vecs.push_back('{"mulh min*min", 5'd11, 3'd0, 32'h80000000, 32'h80000000, 5'd20, 32'h40000000, 1'b0, IL});
        vecs.push_back('{"mulhsu -1*ffffffff", 5'd12, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd21, 32'hFFFFFFFF, 1'b0, IL});
        vecs.push_back('{"mulhu max*max", 5'd13, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd22, 32'hFFFFFFFE, 1'b0, IL});
        vecs.push_back('{"mul -1*3", 5'd10, 3'd0, 32'hFFFFFFFF, 32'd3, 5'd23, 32'hFFFFFFFD, 1'b0, IL});
        vecs.push_back('{"div -7/2", 5'd14, 3'd0, 32'hFFFFFFF9, 32'd2, 5'd24, 32'hFFFFFFFD, 1'b0, IL});
        vecs.push_back('{"rem -7/2", 5'd16, 3'd0, 32'hFFFFFFF9, 32'd2, 5'd25, 32'hFFFFFFFF, 1'b0, IL});
        vecs.push_back('{"divu 5/0", 5'd15, 3'd0, 32'd5, 32'd0, 5'd26, 32'hFFFFFFFF, 1'b0, 0});
        vecs.push_back('{"remu 5/0", 5'd17, 3'd0, 32'd5, 32'd0, 5'd27, 32'd5, 1'b0, 0});
        vecs.push_back('{"div ovf", 5'd14, 3'd0, 32'h80000000, 32'hFFFFFFFF, 5'd28, 32'h80000000, 1'b0, 0});
        vecs.push_back('{"rem ovf", 5'd16, 3'd0, 32'h80000000, 32'hFFFFFFFF, 5'd29, 32'd0, 1'b0, 0});
        vecs.push_back('{"divu min/-1", 5'd15, 3'd0, 32'h80000000, 32'hFFFFFFFF, 5'd30, 32'd0, 1'b0, IL});

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_op = '0; in_btype = '0; in_a = '0; in_b = '0; in_tag = '0;
        repeat (3) tick();
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_res", 64'(out_res), 64'd0);
        chk("reset out_tag", 64'(out_tag), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("ready low in reset", 64'(in_ready), 64'd0);
        reset = 1'b0;
        #1;
        chk("ready after reset", 64'(in_ready), 64'd1);

        // Table-driven directed vectors
        foreach (vecs[i])
            run_op(vecs[i].nm, vecs[i].op, vecs[i].bt, vecs[i].a, vecs[i].b, vecs[i].tag,
                   vecs[i].res, vecs[i].bc, vecs[i].lat);

        // Back-to-back: second DIVU accepted in the first one's result cycle
        drive(5'd15, 3'd0, 32'd100, 32'd7, 5'd3);
        tick();
        scramble();
        wait_check("b2b first divu", IL, 32'd14, 1'b0, 5'd3, 1'b1);
        chk("b2b ready in result", 64'(in_ready), 64'd1);
        drive(5'd15, 3'd0, 32'd1000, 32'd10, 5'd4);
        tick();
        scramble();
        chk("b2b no gap busy", 64'(busy), 64'd1);
        wait_check("b2b second divu", IL, 32'd100, 1'b0, 5'd4, 1'b1);
        tick();

        // Flush in busy cycle 10, with a competing op presented
        drive(5'd13, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7);
        tick();
        scramble();
        repeat (9) tick();
        chk("busy before flush", 64'(busy), 64'd1);
        flush = 1'b1;
        drive(5'd0, 3'd0, 32'd1, 32'd2, 5'd8);
        tick();
        flush = 1'b0;
        scramble();
        chk("flush ready", 64'(in_ready), 64'd1);
        chk("flush busy", 64'(busy), 64'd0);
        nv = 0;
        repeat (40) begin
            if (out_valid) nv++;
            tick();
        end
        chk("flush no result", 64'(nv), 64'd0);
        chk("flush res held", 64'(out_res), 64'(last_res));
        chk("flush tag held", 64'(out_tag), 64'(last_tag));
        $display("[TB] flush mid-busy: valid strobes=%0d", nv);

        // Flush discards a simple op presented in the same cycle
        flush = 1'b1;
        drive(5'd0, 3'd0, 32'd1, 32'd1, 5'd9);
        tick();
        flush = 1'b0;
        scramble();
        chk("flush discard valid", 64'(out_valid), 64'd0);
        chk("flush discard tag", 64'(out_tag), 64'(last_tag));
        $display("[TB] flush with op in idle: out_valid=%0d", out_valid);

        // Reset mid-busy aborts the op and clears the outputs
        drive(5'd14, 3'd0, 32'd1000, 32'd3, 5'd2);
        tick();
        scramble();
        repeat (5) tick();
        reset = 1'b1;
        #1;
        chk("ready low during reset", 64'(in_ready), 64'd0);
        tick();
        chk("mid reset valid", 64'(out_valid), 64'd0);
        chk("mid reset res", 64'(out_res), 64'd0);
        chk("mid reset bcond", 64'(out_bcond), 64'd0);
        chk("mid reset tag", 64'(out_tag), 64'd0);
        chk("mid reset busy", 64'(busy), 64'd0);
        reset = 1'b0;
        #1;
        chk("ready after mid reset", 64'(in_ready), 64'd1);
        nv = 0;
        repeat (40) begin
            if (out_valid) nv++;
            tick();
        end
        chk("reset no result", 64'(nv), 64'd0);
        $display("[TB] reset mid-busy: valid strobes=%0d", nv);

        // Randomized ops against the reference model
        for (int k = 0; k < 150; k++) begin
            rop = 5'($urandom_range(0, 21));
            rbt = 3'($urandom);
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin rb = 32'hFFFFFFFF; if ($urandom_range(0, 1) == 1) ra = 32'h80000000; end
                2: begin rb = $urandom_range(1, 15); ra = $urandom_range(0, 255); end
                3: rb = ra;
                default: rb = $urandom;
            endcase
            m = ref_model(rop, rbt, ra, rb);
            run_op($sformatf("rand%0d op%0d", k, rop), rop, rbt, ra, rb, 5'(k),
                   m[31:0], m[32], ref_lat(rop, ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
